fpga: RTL and testbench
=======================

Name: fpga

Overview:
- 16-node single-wire serial bus transmitter.
- Each node N (1..16) presents a 64-bit data word, a 4-bit destination address and a 4-bit CRC.
- A 16-bit request vector `mod` selects the transmitting node. The block serialises that node's frame onto the one-bit `bus_show` line, one bit per clock.
- Sits at the top of the bus demo as the bus master/serialiser; `bus_show` is the observed bus line.

Parameters:
- FRAME_LEN, 84, total bits per frame (fixed by the format below; not meant to be overridden)
- EOF_LEN, 7, number of recessive end-of-frame bits

Ports:
- clock  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- CRC1..CRC16  input  4 each  CRC field for node 1..16
- Data1..Data16  input  64 each  payload for node 1..16
- receiverAddr1..receiverAddr16  input  4 each  destination address for node 1..16
- mod  input  16  request vector; bit i set = node i+1 requests the bus
- bus_show  output  1  serial bus line, registered; 1 = recessive/idle

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, bit counter=0, bus_show=1 after the edge.
  - Reset mid-frame aborts the frame; no partial resume.
- States: IDLE, TX.
- IDLE:
  - bus_show=1.
  - On a rising edge with mod!=0: select the lowest set bit i (lower index wins).
  - Latch sender address (4 bits, value i), receiverAddr(i+1), Data(i+1) and CRC(i+1) into a shift register.
  - Go to TX; bus_show=0 (SOF) after that same edge.
- mod is sampled only at frame start. Changes during TX are ignored, and latched fields are unaffected by input changes mid-frame.
- Frame order, each field MSB first, one bit per cycle (84 bits):
  - bit 0: SOF = 0
  - bits 1-4: sender address i
  - bits 5-8: receiver address
  - bits 9-72: data[63:0]
  - bits 73-76: CRC[3:0]
  - bits 77-83: EOF = 1 (seven bits)
- Latency: SOF appears on bus_show one clock after the edge that samples mod. bus_show is driven from a flop only (no combinational path from inputs).
- End of frame, at the edge following the last EOF bit:
  - mod!=0: immediately start a new frame (SOF=0 that edge), re-arbitrating on the current mod. Back-to-back frame period = 84 cycles.
  - mod==0: return to IDLE, bus_show stays 1.
- Multiple mod bits set: only the lowest-index node transmits. The others are not queued.
- mod==0 at all times: bus_show constant 1.
- Bit counter is 7 bits; it wraps to 0 only on frame restart/idle, never mid-frame.

Optional Feature:
- Macro FPGA_CRC_GEN_EN.
- Defined:
  - CRC field is generated internally, ignoring CRCn inputs.
  - Polynomial CRC-4 x^4+x+1, init 0000, no final XOR.
  - Computed over the 72 bits sender addr, receiver addr, data, MSB first.
  - Computed at latch time or bit-serially; either way it must be ready by bit 73.
- Not defined: CRC(i+1) input is transmitted verbatim. Frame length and timing are identical in both builds.

Test Plan:
- Reset/idle: reset=1 for 2 cycles, mod=0 → bus_show=1 every cycle for 200 cycles.
- Single node: Data2=1, receiverAddr2=2, CRC2=1, mod=16'h0002 → bus_show sequence:
  - 0 | 0001 | 0010 | 63×0 then 1 | 0001 | 1111111
  - SOF one cycle after the sampling edge; 84 bits total.
- Sequence change: mod=2 for 84 cycles, then 4, then 8, then 0, with Data3=Data4=0, receiverAddr3=3, receiverAddr4=4, CRC3=CRC4=1 →
  - frames back-to-back from nodes 2, 3, 4 with sender fields 0001, 0010, 0011 and receiver fields 0010, 0011, 0100
  - then idle 1.
- Arbitration: mod=16'h8006 → sender field 0001 (node 2). Change mod to 16'h0004 at bit 40 → current frame unchanged; next frame sender 0010.
- Reset mid-frame: assert reset at bit 30 of a node-2 frame → bus_show=1 the next cycle. With mod=2 held, a fresh SOF follows one cycle after reset deasserts.
- FPGA_CRC_GEN_EN defined: Data1=64'hFFFF_FFFF_FFFF_FFFF, receiverAddr1=1, mod=1 → bits 73-76 equal the bench-model CRC-4 of {0000,0001,Data1}, independent of the CRC1 input value.

Source files
------------

// File: rtl/fpga.sv
// 16-node single-wire bus serialiser: lowest requesting node's frame goes out MSB first.
// Define FPGA_CRC_GEN_EN to replace the CRCn inputs with an internal CRC-4 (x^4+x+1).
module fpga #(
    parameter int FRAME_LEN = 84,
    parameter int EOF_LEN   = 7
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  CRC1,  CRC2,  CRC3,  CRC4,  CRC5,  CRC6,  CRC7,  CRC8,
    input  logic [3:0]  CRC9,  CRC10, CRC11, CRC12, CRC13, CRC14, CRC15, CRC16,
    input  logic [63:0] Data1,  Data2,  Data3,  Data4,  Data5,  Data6,  Data7,  Data8,
    input  logic [63:0] Data9,  Data10, Data11, Data12, Data13, Data14, Data15, Data16,
    input  logic [3:0]  receiverAddr1,  receiverAddr2,  receiverAddr3,  receiverAddr4,
    input  logic [3:0]  receiverAddr5,  receiverAddr6,  receiverAddr7,  receiverAddr8,
    input  logic [3:0]  receiverAddr9,  receiverAddr10, receiverAddr11, receiverAddr12,
    input  logic [3:0]  receiverAddr13, receiverAddr14, receiverAddr15, receiverAddr16,
    input  logic [15:0] mod,
    output logic        bus_show
);
    localparam int SH_W = FRAME_LEN - 1;
    localparam logic [6:0] LAST = 7'(FRAME_LEN - 1);

    typedef enum logic {IDLE, TX} state_t;

    logic [15:0][63:0] data_a;
    logic [15:0][3:0]  crc_a;
    logic [15:0][3:0]  rcv_a;

    assign data_a = {Data16, Data15, Data14, Data13, Data12, Data11, Data10, Data9,
                     Data8,  Data7,  Data6,  Data5,  Data4,  Data3,  Data2,  Data1};
    assign crc_a  = {CRC16, CRC15, CRC14, CRC13, CRC12, CRC11, CRC10, CRC9,
                     CRC8,  CRC7,  CRC6,  CRC5,  CRC4,  CRC3,  CRC2,  CRC1};
    assign rcv_a  = {receiverAddr16, receiverAddr15, receiverAddr14, receiverAddr13,
                     receiverAddr12, receiverAddr11, receiverAddr10, receiverAddr9,
                     receiverAddr8,  receiverAddr7,  receiverAddr6,  receiverAddr5,
                     receiverAddr4,  receiverAddr3,  receiverAddr2,  receiverAddr1};

    state_t          state, state_n;
    logic [6:0]      cnt, cnt_n;
    logic [SH_W-1:0] sh, sh_n;
    logic            bus_n;
    logic [3:0]      sel;
    logic [3:0]      crc_sel;
    logic [SH_W-1:0] load;

`ifdef FPGA_CRC_GEN_EN
    function automatic logic [3:0] crc4(input logic [71:0] m);
        logic [3:0] c;
        logic       fb;
        c = '0;
        for (int i = 71; i >= 0; i--) begin
            fb = c[3] ^ m[i];
            c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
        end
        return c;
    endfunction
    assign crc_sel = crc4({sel, rcv_a[sel], data_a[sel]});
`else
    assign crc_sel = crc_a[sel];
`endif

    // Scan high to low so the lowest set request bit is the one left standing.
    always_comb begin
        sel = '0;
        for (int i = 15; i >= 0; i--)
            if (mod[i]) sel = 4'(i);
    end

    assign load = {sel, rcv_a[sel], data_a[sel], crc_sel, {EOF_LEN{1'b1}}};

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sh_n    = sh;
        bus_n   = bus_show;
        if (state == TX && cnt != LAST) begin
            bus_n = sh[SH_W-1];
            sh_n  = {sh[SH_W-2:0], 1'b1};
            cnt_n = cnt + 7'd1;
        end else if (mod != '0) begin
            // Frame start from idle or straight after the last EOF bit; SOF is bit 0.
            state_n = TX;
            bus_n   = 1'b0;
            sh_n    = load;
            cnt_n   = '0;
        end else begin
            state_n = IDLE;
            bus_n   = 1'b1;
            cnt_n   = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            sh       <= '1;
            bus_show <= 1'b1;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            sh       <= sh_n;
            bus_show <= bus_n;
        end
    end
endmodule

// File: tb/tb_fpga.sv
// Directed bench for the fpga bus serialiser; frames captured bit by bit on the falling edge.
module tb_fpga;
    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] mod;
    logic        bus_show;
    logic [3:0]  crc_t [1:16];
    logic [63:0] dat_t [1:16];
    logic [3:0]  rcv_t [1:16];

    int n_run = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    fpga dut (
        .clock(clock), .reset(reset),
        .CRC1(crc_t[1]),   .CRC2(crc_t[2]),   .CRC3(crc_t[3]),   .CRC4(crc_t[4]),
        .CRC5(crc_t[5]),   .CRC6(crc_t[6]),   .CRC7(crc_t[7]),   .CRC8(crc_t[8]),
        .CRC9(crc_t[9]),   .CRC10(crc_t[10]), .CRC11(crc_t[11]), .CRC12(crc_t[12]),
        .CRC13(crc_t[13]), .CRC14(crc_t[14]), .CRC15(crc_t[15]), .CRC16(crc_t[16]),
        .Data1(dat_t[1]),   .Data2(dat_t[2]),   .Data3(dat_t[3]),   .Data4(dat_t[4]),
        .Data5(dat_t[5]),   .Data6(dat_t[6]),   .Data7(dat_t[7]),   .Data8(dat_t[8]),
        .Data9(dat_t[9]),   .Data10(dat_t[10]), .Data11(dat_t[11]), .Data12(dat_t[12]),
        .Data13(dat_t[13]), .Data14(dat_t[14]), .Data15(dat_t[15]), .Data16(dat_t[16]),
        .receiverAddr1(rcv_t[1]),   .receiverAddr2(rcv_t[2]),   .receiverAddr3(rcv_t[3]),
        .receiverAddr4(rcv_t[4]),   .receiverAddr5(rcv_t[5]),   .receiverAddr6(rcv_t[6]),
        .receiverAddr7(rcv_t[7]),   .receiverAddr8(rcv_t[8]),   .receiverAddr9(rcv_t[9]),
        .receiverAddr10(rcv_t[10]), .receiverAddr11(rcv_t[11]), .receiverAddr12(rcv_t[12]),
        .receiverAddr13(rcv_t[13]), .receiverAddr14(rcv_t[14]), .receiverAddr15(rcv_t[15]),
        .receiverAddr16(rcv_t[16]),
        .mod(mod), .bus_show(bus_show)
    );

    task automatic chk(input string tag, input logic [83:0] got, input logic [83:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] crc_model(input logic [71:0] m);
        logic [3:0] c = 4'h0;
        logic       fb;
        for (int i = 71; i >= 0; i--) begin
            fb = c[3] ^ m[i];
            c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
        end
        return c;
    endfunction

    // Expected 84-bit frame for node n, SOF in the MSB.
    function automatic logic [83:0] frame(input int n);
        logic [3:0] s = 4'(n - 1);
        logic [3:0] c;
`ifdef FPGA_CRC_GEN_EN
        c = crc_model({s, rcv_t[n], dat_t[n]});
`else
        c = crc_t[n];
`endif
        return {1'b0, s, rcv_t[n], dat_t[n], c, 7'h7F};
    endfunction

    // First call must be made at the falling edge just before the sampling rising edge.
    // Optionally writes mod_new at bit chg_at (mid-frame change).
    task automatic capture(output logic [83:0] got, input int chg_at, input logic [15:0] mod_new);
        for (int k = 0; k < 84; k++) begin
            @(negedge clock);
            got[83-k] = bus_show;
            if (k == chg_at) mod = mod_new;
        end
    endtask

    logic [83:0] got;
    logic [83:0] exp_a, exp_b;

    initial begin
        reset = 1'b1;
        mod   = '0;
        for (int i = 1; i <= 16; i++) begin
            crc_t[i] = 4'h0;
            dat_t[i] = '0;
            rcv_t[i] = 4'h0;
        end
        dat_t[2] = 64'd1; rcv_t[2] = 4'd2; crc_t[2] = 4'd1;
        dat_t[3] = 64'd0; rcv_t[3] = 4'd3; crc_t[3] = 4'd1;
        dat_t[4] = 64'd0; rcv_t[4] = 4'd4; crc_t[4] = 4'd1;
        repeat (2) @(negedge clock);
        chk("reset_bus", 84'(bus_show), 84'd1);
        reset = 1'b0;

        // Idle with no requests
        for (int c = 0; c < 200; c++) begin
            @(negedge clock);
            chk("idle", 84'(bus_show), 84'd1);
        end

        // Single node 2, dropped right after start; hand-built expected frame too
        mod = 16'h0002;
        capture(got, 0, 16'h0000);
        chk("node2_frame", got, frame(2));
        chk("node2_hand", got, {1'b0, 4'b0001, 4'b0010, 64'd1, 4'b0001, 7'b1111111});
        @(negedge clock);
        chk("node2_idle_after", 84'(bus_show), 84'd1);
        repeat (5) @(negedge clock);

        // Back-to-back 2 -> 3 -> 4 -> idle
        mod = 16'h0002;
        capture(got, 10, 16'h0004);
        chk("seq_n2", got, frame(2));
        capture(got, 10, 16'h0008);
        chk("seq_n3", got, frame(3));
        chk("seq_n3_hdr", 84'(got[82:75]), 84'h23);
        capture(got, 10, 16'h0000);
        chk("seq_n4", got, frame(4));
        chk("seq_n4_hdr", 84'(got[82:75]), 84'h34);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            chk("seq_idle", 84'(bus_show), 84'd1);
        end

        // Arbitration: lowest bit wins; mid-frame change only affects next frame
        mod = 16'h8006;
        capture(got, 40, 16'h0004);
        chk("arb_n2", got, frame(2));
        capture(got, 10, 16'h0000);
        chk("arb_next_n3", got, frame(3));
        chk("arb_next_sender", 84'(got[82:79]), 84'h2);
        @(negedge clock);
        chk("arb_idle", 84'(bus_show), 84'd1);

        // Reset at bit 30 of a node-2 frame
        mod = 16'h0002;
        for (int k = 0; k <= 30; k++) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("midreset_bus", 84'(bus_show), 84'd1);
        reset = 1'b0;
        capture(got, 83, 16'h0000);
        chk("post_reset_frame", got, frame(2));
        @(negedge clock);
        chk("post_reset_idle", 84'(bus_show), 84'd1);

        // Node 1, all-ones data; two CRC1 input values
        dat_t[1] = 64'hFFFF_FFFF_FFFF_FFFF; rcv_t[1] = 4'd1; crc_t[1] = 4'hA;
        mod = 16'h0001;
        capture(got, 0, 16'h0001);
        exp_a = frame(1);
        chk("crc_a_frame", got, exp_a);
        crc_t[1] = 4'h5;
        capture(got, 0, 16'h0000);
        exp_b = frame(1);
        chk("crc_b_frame", got, exp_b);
`ifdef FPGA_CRC_GEN_EN
        chk("crc_gen_field", 84'(got[10:7]), 84'(crc_model({4'h0, 4'h1, 64'hFFFF_FFFF_FFFF_FFFF})));
`else
        chk("crc_pass_field", 84'(got[10:7]), 84'h5);
`endif
        @(negedge clock);
        chk("final_idle", 84'(bus_show), 84'd1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
